// File: rtl/keypad_emulador.sv
// keypad_emulador: replays queued key codes as timed presses toward a row scanner.
// Define KEYPAD_BOUNCE_EN to add LFSR-driven contact bounce at the start of each press.
module keypad_emulador #(
    parameter int HOLD_CYCLES   = 2000000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int DEPTH         = 8,
    parameter int BOUNCE_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [3:0]               push_key,
    output logic                     push_ready,
    input  logic [3:0]               fila,
    output logic [3:0]               columna,
    output logic                     pressed,
    output logic [3:0]               key_actual,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      key_q, key_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [3:0]      mem_q [DEPTH];
    logic [3:0]      head;
    logic            pop;
    logic            do_push;
    logic            full;
    logic            contact;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == FULL_CNT);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ready = !full || pop;
    assign do_push    = push_valid && push_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign pressed    = (state_q == S_PRESS);
    assign key_actual = key_q;
    assign busy       = (state_q != S_IDLE) || (count != '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        key_d   = key_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    key_d   = head;
                    timer_d = HOLD_LD;
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LD;
                    state_d = S_RELEASE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_RELEASE: begin
                if (timer_q == '0) begin
                    if (count != '0) begin
                        pop     = 1'b1;
                        key_d   = head;
                        timer_d = HOLD_LD;
                        state_d = S_PRESS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            key_q    <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            key_q    <= key_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_key;
        end
    end

`ifdef KEYPAD_BOUNCE_EN
    localparam int BW = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BOUNCE_LEN = BW'(BOUNCE_CYCLES);

    logic [15:0]   lfsr_q, lfsr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        bcnt_d = bcnt_q;
        if (pop) begin
            bcnt_d = '0;
        end else if (bcnt_q < BOUNCE_LEN) begin
            bcnt_d = bcnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
            bcnt_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign contact = pressed && ((bcnt_q >= BOUNCE_LEN) || lfsr_q[0]);
`else
    logic unused_bounce;
    assign unused_bounce = (BOUNCE_CYCLES > 0);
    assign contact       = pressed;
`endif

    // Switch model: only the held key's own row and column interact.
    always_comb begin
        columna = 4'hF;
        if (contact && !fila[key_q[3:2]]) begin
            columna[key_q[1:0]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulador.sv
// tb_keypad_emulador: directed scoreboard bench for keypad_emulador.
// Bounce checks run only when KEYPAD_BOUNCE_EN is defined.
module tb_keypad_emulador;

    localparam int HOLD  = 4;
    localparam int GAP   = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_valid = 1'b0;
    logic [3:0] push_key = 4'h0;
    logic [3:0] fila = 4'hF;
    logic       push_ready;
    logic [3:0] columna;
    logic       pressed;
    logic [3:0] key_actual;
    logic       busy;
    logic [2:0] count;

    always #5 clk = ~clk;

    keypad_emulador #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP),
        .DEPTH(DEPTH),
        .BOUNCE_CYCLES(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_valid(push_valid),
        .push_key(push_key),
        .push_ready(push_ready),
        .fila(fila),
        .columna(columna),
        .pressed(pressed),
        .key_actual(key_actual),
        .busy(busy),
        .count(count)
    );

`ifdef KEYPAD_BOUNCE_EN
    logic       pushb_valid = 1'b0;
    logic [3:0] pushb_key = 4'h0;
    logic [3:0] filab = 4'hF;
    logic       pushb_ready;
    logic [3:0] columnab;
    logic       pressedb;
    logic [3:0] keyb;
    logic       busyb;
    logic [2:0] countb;
    logic [15:0] lfsr_m;

    keypad_emulador #(
        .HOLD_CYCLES(20),
        .GAP_CYCLES(GAP),
        .DEPTH(DEPTH),
        .BOUNCE_CYCLES(8)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .push_valid(pushb_valid),
        .push_key(pushb_key),
        .push_ready(pushb_ready),
        .fila(filab),
        .columna(columnab),
        .pressed(pressedb),
        .key_actual(keyb),
        .busy(busyb),
        .count(countb)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
`endif

    int         checks = 0;
    int         failures = 0;
    logic [3:0] sb[$];
    logic       prev_p = 1'b0;
    int         press_len = 0;
    int         gap_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pressed && !prev_p) begin
            press_len = 1;
            if (sb.size() == 0) chk("unexpected_press", 32'(pressed), 32'd0);
            else chk("key_order", 32'(key_actual), 32'(sb.pop_front()));
            if (gap_len != 0) chk("gap_len", gap_len, GAP);
            gap_len = 0;
        end else if (pressed) begin
            press_len++;
        end
        if (!pressed && prev_p) begin
            chk("press_len", press_len, HOLD);
            gap_len = 1;
        end else if (!pressed && gap_len != 0) begin
            gap_len++;
        end
        if (!busy) gap_len = 0;
        prev_p = pressed;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && busy; i++) step();
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_key", 32'(key_actual), 32'd0);
        fila = 4'h0;
        #1;
        chk("rst_columna", 32'(columna), 32'hF);
        fila = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single key 6
        push_valid = 1'b1;
        push_key = 4'h6;
        sb.push_back(4'h6);
        step();
        chk("single_count", 32'(count), 32'd1);
        chk("single_not_yet", 32'(pressed), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        push_valid = 1'b0;
        step();
        chk("press_latency", 32'(pressed), 32'd1);
        fila = 4'b1101;
        #1;
        chk("col_row1", 32'(columna), 32'hB);
        fila = 4'b1110;
        #1;
        chk("col_other_row", 32'(columna), 32'hF);
        fila = 4'hF;
        repeat (6) step();
        chk("busy_in_gap", 32'(busy), 32'd1);
        fila = 4'h0;
        #1;
        chk("col_released", 32'(columna), 32'hF);
        fila = 4'hF;
        step();
        chk("busy_falls", 32'(busy), 32'd0);

        // Lead key, then fill FIFO during its press
        push_valid = 1'b1;
        push_key = 4'h1;
        sb.push_back(4'h1);
        step();
        push_valid = 1'b0;
        step();
        push_valid = 1'b1;
        foreach (sb[i]) begin end
        push_key = 4'h0; sb.push_back(4'h0); step();
        push_key = 4'h5; sb.push_back(4'h5); step();
        push_key = 4'hA; sb.push_back(4'hA); step();
        push_key = 4'hF; sb.push_back(4'hF); step();
        chk("count_full", 32'(count), 32'd4);
        chk("ready_full", 32'(push_ready), 32'd0);
        push_key = 4'h3;
        step();
        chk("push_ignored", 32'(count), 32'd4);
        push_key = 4'h9;
        step();
        chk("still_full", 32'(count), 32'd4);
        chk("ready_on_pop", 32'(push_ready), 32'd1);
        sb.push_back(4'h9);
        step();
        chk("push_pop_count", 32'(count), 32'd4);
        chk("push_pop_pressed", 32'(pressed), 32'd1);
        push_valid = 1'b0;
        drain("seq_timeout");
        chk("seq_sb_empty", 32'(sb.size()), 32'd0);

        // All rows low during key E
        push_valid = 1'b1;
        push_key = 4'hE;
        sb.push_back(4'hE);
        step();
        push_valid = 1'b0;
        step();
        chk("e_pressed", 32'(pressed), 32'd1);
        fila = 4'b0000;
        #1;
        chk("col_all_rows", 32'(columna), 32'hB);
        fila = 4'b0111;
        #1;
        chk("col_row3", 32'(columna), 32'hB);
        fila = 4'b1011;
        #1;
        chk("col_row2_only", 32'(columna), 32'hF);
        fila = 4'hF;
        drain("e_timeout");

        // Reset mid-press with entries queued
        push_valid = 1'b1;
        push_key = 4'h3;
        sb.push_back(4'h3);
        step();
        push_key = 4'h7;
        step();
        push_key = 4'hB;
        step();
        push_valid = 1'b0;
        chk("mid_count", 32'(count), 32'd2);
        chk("mid_pressed", 32'(pressed), 32'd1);
        fila = 4'b1110;
        #1;
        chk("col_key3", 32'(columna), 32'h7);
        rst = 1'b1;
        #1;
        chk("rst_mid_col", 32'(columna), 32'hF);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_pressed", 32'(pressed), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_p = 1'b0;
        gap_len = 0;
        repeat (10) step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_col", 32'(columna), 32'hF);
        fila = 4'hF;

        // New push after reset plays
        push_valid = 1'b1;
        push_key = 4'h2;
        sb.push_back(4'h2);
        step();
        push_valid = 1'b0;
        step();
        chk("after_rst_press", 32'(pressed), 32'd1);
        drain("after_rst_timeout");
        chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef KEYPAD_BOUNCE_EN
        pushb_valid = 1'b1;
        pushb_key = 4'h0;
        filab = 4'b1110;
        @(posedge clk);
        #1;
        pushb_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b_pressed", 32'(pressedb), 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk("bounce_col0", 32'(columnab[0]),
                (i < 8) ? 32'(~lfsr_m[0]) : 32'd0);
            chk("bounce_held", 32'(pressedb), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("b_released", 32'(pressedb), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
